// File: rtl/uart_tx_driver_if.sv
// rtl/uart_tx_driver_if.sv - byte handshake into the UART transmitter FIFO
interface uart_tx_driver_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_driver.sv
// rtl/uart_tx_driver.sv - byte FIFO plus 8N1 UART serialiser, LSB first
// Optional macro UART_TX_PARITY_EN adds an even parity bit after bit 7.
module uart_tx_driver #(
  parameter int CLKS_PER_BIT = 5,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          resetb,
  input  logic                          enable,
  uart_tx_driver_if.slave               tx,
  output logic                          ser_tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] count;
  logic          full, empty, push, pop;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    shift, shift_n;
  logic          ser_q, ser_n;
  logic          bit_end;

  assign full        = (count == LW'(FIFO_DEPTH));
  assign empty       = (count == '0);
  // Ready is held low during reset so nothing is accepted before the FIFO is clean.
  assign tx.tx_ready = resetb & ~full;
  assign push        = tx.tx_valid & tx.tx_ready;
  assign fifo_level  = count;
  assign busy        = (state != S_IDLE);
  assign ser_tx      = ser_q;
  assign bit_end     = (cnt == CW'(CLKS_PER_BIT - 1));

  // Circular byte FIFO; pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk) begin
    if (!resetb) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= tx.tx_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Serialiser state register; reset abandons any partial frame and idles the line high.
  always_ff @(posedge clk) begin
    if (!resetb) begin
      state <= S_IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
      ser_q <= 1'b1;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      shift <= shift_n;
      ser_q <= ser_n;
    end
  end

  // Next-state logic; ser_n is the line value for the cycle after this edge.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shift_n = shift;
    ser_n   = ser_q;
    pop     = 1'b0;
    case (state)
      S_IDLE: begin
        ser_n = 1'b1;
        cnt_n = '0;
        if (enable && !empty) begin
          pop     = 1'b1;
          shift_n = mem[rd_ptr];
          state_n = S_START;
          ser_n   = 1'b0;
        end
      end
      S_START: begin
        cnt_n = cnt + 1'b1;
        if (bit_end) begin
          cnt_n   = '0;
          idx_n   = 3'd0;
          state_n = S_DATA;
          ser_n   = shift[0];
        end
      end
      S_DATA: begin
        cnt_n = cnt + 1'b1;
        if (bit_end) begin
          cnt_n = '0;
          if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_n = S_PARITY;
            ser_n   = ^shift;
`else
            state_n = S_STOP;
            ser_n   = 1'b1;
`endif
          end else begin
            idx_n = idx + 3'd1;
            ser_n = shift[idx + 3'd1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        cnt_n = cnt + 1'b1;
        if (bit_end) begin
          cnt_n   = '0;
          state_n = S_STOP;
          ser_n   = 1'b1;
        end
      end
`endif
      S_STOP: begin
        cnt_n = cnt + 1'b1;
        if (bit_end) begin
          cnt_n = '0;
          // Back-to-back frames: the next start bit follows the stop bit directly.
          if (enable && !empty) begin
            pop     = 1'b1;
            shift_n = mem[rd_ptr];
            state_n = S_START;
            ser_n   = 1'b0;
          end else begin
            state_n = S_IDLE;
            ser_n   = 1'b1;
          end
        end
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
        ser_n   = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_driver.sv
// tb/tb_uart_tx_driver.sv - randomized and directed bench for uart_tx_driver against a frame-level model
module tb_uart_tx_driver;
  localparam int CPB   = 5;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CPB;

  logic       clk = 1'b0;
  logic       resetb = 1'b0;
  logic       enable = 1'b0;
  logic       ser_tx, busy;
  logic [2:0] fifo_level;

  uart_tx_driver_if tx_if();

  always #5 clk = ~clk;

  uart_tx_driver #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .resetb(resetb), .enable(enable), .tx(tx_if),
    .ser_tx(ser_tx), .busy(busy), .fifo_level(fifo_level)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: queued bytes, plus the remaining per-cycle line values of the current frame.
  logic [7:0] q_m[$];
  logic [7:0] log_m[$];
  logic [7:0] rx_q[$];
  bit         line_m[$];
  int         fall_cnt = 0;

  task automatic start_frame(input logic [7:0] b);
    for (int c = 0; c < CPB; c++) line_m.push_back(1'b0);
    for (int k = 0; k < 8; k++)
      for (int c = 0; c < CPB; c++) line_m.push_back(b[k]);
`ifdef UART_TX_PARITY_EN
    for (int c = 0; c < CPB; c++) line_m.push_back(^b);
`endif
    for (int c = 0; c < CPB; c++) line_m.push_back(1'b1);
  endtask

  // Receiver state
  bit         rx_act = 1'b0;
  int         rx_cnt = 0;
  logic [7:0] rx_sh = '0;
  logic       prev_ser = 1'b1;

  // Advance the model on each edge, then compare DUT outputs and run the bench receiver.
  always @(posedge clk) begin
    bit         do_push;
    logic [7:0] pd;
    logic [7:0] b;
    logic       ser_e;
    if (!resetb) begin
      q_m.delete();
      line_m.delete();
    end else begin
      do_push = tx_if.tx_valid && (q_m.size() < DEPTH);
      pd      = tx_if.tx_data;
      if (line_m.size() > 0) void'(line_m.pop_front());
      if (line_m.size() == 0 && enable && q_m.size() > 0) begin
        b = q_m.pop_front();
        log_m.push_back(b);
        start_frame(b);
      end
      if (do_push) q_m.push_back(pd);
    end
    #1;
    ser_e = (line_m.size() > 0) ? line_m[0] : 1'b1;
    chk("ser_tx", ser_tx, ser_e);
    chk("busy", busy, (line_m.size() > 0) ? 1 : 0);
    chk("fifo_level", fifo_level, q_m.size());
    chk("tx_ready", tx_if.tx_ready, (resetb && q_m.size() < DEPTH) ? 1 : 0);
    if (!resetb) begin
      rx_act = 1'b0;
    end else if (!rx_act) begin
      if (prev_ser && !ser_tx) begin
        rx_act = 1'b1;
        rx_cnt = 0;
      end
    end else begin
      rx_cnt++;
      for (int k = 0; k < 8; k++)
        if (rx_cnt == CPB * (k + 1) + CPB / 2) rx_sh[k] = ser_tx;
      if (rx_cnt == (NBITS - 1) * CPB + CPB / 2) begin
        rx_q.push_back(rx_sh);
        rx_act = 1'b0;
      end
    end
    if (prev_ser === 1'b1 && ser_tx === 1'b0) fall_cnt++;
    prev_ser = ser_tx;
  end

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin
      @(posedge clk); #2;
      n++;
    end while ((busy || fifo_level != 0) && n < budget);
    if (busy || fifo_level != 0) chk("idle_timeout", 1, 0);
  endtask

  // Push one byte into an idle block and check every line cycle against a hand-written segment pattern.
  task automatic check_frame(input logic [7:0] b, input logic [10:0] segs, input string name);
    int bad = 0;
    @(negedge clk); tx_if.tx_valid = 1'b1; tx_if.tx_data = b;
    @(posedge clk);
    @(negedge clk); tx_if.tx_valid = 1'b0;
    for (int i = 1; i <= FRAME; i++) begin
      @(posedge clk); #2;
      if (ser_tx !== segs[(i - 1) / CPB]) bad++;
      if (busy !== 1'b1) bad++;
    end
    chk({name, "_wave_bad_cycles"}, bad, 0);
    @(posedge clk); #2;
    chk({name, "_busy_end"}, busy, 0);
  endtask

  logic [7:0] vals [5];
  logic [7:0] hi [3];
  int         run;

  initial begin
    tx_if.tx_valid = 1'b0;
    tx_if.tx_data  = 8'h00;
    resetb = 1'b0;
    enable = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ser", ser_tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ready", tx_if.tx_ready, 0);
    resetb = 1'b1;
    @(posedge clk); #2;
    chk("ready_after_release", tx_if.tx_ready, 1);

    // Single 0x55 frame
    rx_q.delete();
`ifdef UART_TX_PARITY_EN
    check_frame(8'h55, 11'b10010101010, "b55");
`else
    check_frame(8'h55, 11'b11010101010, "b55");
`endif
    chk("b55_rx_count", rx_q.size(), 1);
    if (rx_q.size() > 0) chk("b55_rx_byte", rx_q[0], 8'h55);

    // "Hi\n" back-to-back
    rx_q.delete();
    hi[0] = 8'h48; hi[1] = 8'h69; hi[2] = 8'h0A;
    run = 0;
    @(negedge clk); tx_if.tx_valid = 1'b1; tx_if.tx_data = hi[0];
    for (int n = 0; n < 400; n++) begin
      @(posedge clk); #2;
      if (busy) run++;
      else if (run > 0) break;
      @(negedge clk);
      if (n < 2) tx_if.tx_data = hi[n + 1];
      else tx_if.tx_valid = 1'b0;
    end
    tx_if.tx_valid = 1'b0;
    chk("hi_busy_run", run, 3 * FRAME);
    chk("hi_rx_count", rx_q.size(), 3);
    for (int i = 0; i < 3 && i < rx_q.size(); i++) chk("hi_rx_byte", rx_q[i], hi[i]);

    // Overflow while disabled
    rx_q.delete();
    for (int i = 0; i < 5; i++) vals[i] = 8'($urandom_range(0, 255));
    @(negedge clk); enable = 1'b0; tx_if.tx_valid = 1'b1; tx_if.tx_data = vals[0];
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #2;
      if (i == 3) begin
        chk("ovf_ready_after4", tx_if.tx_ready, 0);
        chk("ovf_level_after4", fifo_level, 4);
      end
      @(negedge clk);
      if (i < 4) tx_if.tx_data = vals[i + 1];
      else tx_if.tx_valid = 1'b0;
    end
    chk("ovf_level_after5", fifo_level, 4);
    chk("ovf_busy_disabled", busy, 0);
    enable = 1'b1;
    wait_idle(2000);
    chk("ovf_rx_count", rx_q.size(), 4);
    for (int i = 0; i < 4 && i < rx_q.size(); i++) chk("ovf_rx_order", rx_q[i], vals[i]);

    // Reset during bit 3 of a 0x00 frame
    rx_q.delete();
    @(negedge clk); tx_if.tx_valid = 1'b1; tx_if.tx_data = 8'h00;
    @(posedge clk);
    @(negedge clk); tx_if.tx_valid = 1'b0;
    repeat (22) @(negedge clk);
    chk("mid_ser_low", ser_tx, 0);
    resetb = 1'b0;
    @(posedge clk); #2;
    chk("mid_rst_ser", ser_tx, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_level", fifo_level, 0);
    fall_cnt = 0;
    @(negedge clk); resetb = 1'b1;
    repeat (100) @(negedge clk);
    chk("mid_rst_no_fall", fall_cnt, 0);
    chk("mid_rst_no_rx", rx_q.size(), 0);

`ifdef UART_TX_PARITY_EN
    check_frame(8'h07, 11'b11000001110, "p07");
    check_frame(8'h03, 11'b10000000110, "p03");
`endif

    // Randomized traffic with enable toggling
    rx_q.delete();
    log_m.delete();
    for (int n = 0; n < 2500; n++) begin
      @(negedge clk);
      tx_if.tx_valid = ($urandom_range(0, 2) == 0);
      tx_if.tx_data  = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 49) == 0) enable = ~enable;
    end
    @(negedge clk);
    tx_if.tx_valid = 1'b0;
    enable = 1'b1;
    wait_idle(2000);
    chk("rnd_rx_count", rx_q.size(), log_m.size());
    chk("rnd_some_traffic", (log_m.size() > 10) ? 1 : 0, 1);
    for (int i = 0; i < rx_q.size() && i < log_m.size(); i++) chk("rnd_rx_byte", rx_q[i], log_m[i]);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
